gost_gamma_ctrl: RTL and testbench

- Host-side sequencer that drives the gost_28147_89 core interface (kload/key, load/mode/pdata, done/cdata) and implements GOST 28147-89 gamma (counter) mode on a 64-bit block stream.
- Sits between a valid/ready data path and one gost_28147_89 instance.
- Loads the key, encrypts the synchro (IV), steps the N3/N4 counters for each block, encrypts the counter and XORs the result into the data.
- Encrypt and decrypt are the same operation.

---
 rtl/gost_gamma_ctrl.sv | 137 +++++++++++++
 tb/tb_gost_gamma_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gost_gamma_ctrl.sv
// gost_gamma_ctrl: GOST 28147-89 gamma (counter) mode sequencer driving one gost_28147_89 core
// Optional feature macro: GOST_GAMMA_CFB_EN (gamma with feedback when cfb=1 at iv_wr).
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   key_in, key_wr                 256-bit key and its load strobe
//   iv_in, iv_wr, cfb              synchro, sequence-start strobe, feedback select
//   din, din_valid, din_ready      input block stream
//   dout, dout_valid, dout_ready   output block stream, dout = din ^ gamma
//   busy                           high outside IDLE and READY
//   core_kload/key/load/mode/pdata registered drive of the core
//   core_done, core_cdata          core result (done is a level)
module gost_gamma_ctrl #(
  parameter logic [31:0] C1 = 32'h01010101,
  parameter logic [31:0] C2 = 32'h01010104
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key_in,
  input  logic         key_wr,
  input  logic [63:0]  iv_in,
  input  logic         iv_wr,
  input  logic         cfb,
  input  logic [63:0]  din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [63:0]  dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy,
  output logic         core_kload,
  output logic [255:0] core_key,
  output logic         core_load,
  output logic         core_mode,
  output logic [63:0]  core_pdata,
  input  logic         core_done,
  input  logic [63:0]  core_cdata
);
  typedef enum logic [3:0] {IDLE, KEY, SYNC_LD, SYNC_WT, READY, STEP, BLK_LD, BLK_WT, OUT} state_t;
  state_t r_state, w_next;
  logic r_key_ok, r_pend, r_done_q;
  logic [63:0] r_iv, r_din;
  logic [31:0] r_n3, r_n4;
  logic [32:0] w_s4;
  logic [63:0] w_blk;
  logic w_free, w_kwr, w_ivwr, w_rise, w_take, w_cfb;
  assign w_free = r_state == IDLE || r_state == READY;
  assign w_kwr = w_free & key_wr;
  // iv_wr together with key_wr is honoured even before the first key: the key loads first
  assign w_ivwr = w_free & iv_wr & (r_key_ok | key_wr);
  assign w_rise = core_done & ~r_done_q;
  assign w_s4 = {1'b0, r_n4} + {1'b0, C1};
  // a strobe in READY wins over data, so the block is not accepted that cycle
  assign din_ready = r_state == READY && !key_wr && !iv_wr;
  assign w_take = din_valid & din_ready;
  assign busy = ~w_free;
  assign core_mode = 1'b0;
`ifdef GOST_GAMMA_CFB_EN
  logic r_cfb;
  logic [63:0] r_g;
  assign w_cfb = r_cfb;
  assign w_blk = r_cfb ? r_g : {r_n4, r_n3};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cfb <= 1'b0;
      r_g <= '0;
    end else begin
      if (w_ivwr) r_cfb <= cfb;
      if (r_state == SYNC_WT && w_rise) r_g <= core_cdata;
      if (r_state == BLK_WT && w_rise) r_g <= r_din ^ core_cdata;
    end
`else
  logic w_unused;
  assign w_unused = cfb;
  assign w_cfb = 1'b0;
  assign w_blk = {r_n4, r_n3};
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, READY: w_next = w_kwr ? KEY : w_ivwr ? SYNC_LD : w_take ? (w_cfb ? BLK_LD : STEP) : r_state;
      KEY:     w_next = r_pend ? SYNC_LD : IDLE;
      SYNC_LD: w_next = SYNC_WT;
      SYNC_WT: w_next = w_rise ? READY : SYNC_WT;
      STEP:    w_next = BLK_LD;
      BLK_LD:  w_next = BLK_WT;
      BLK_WT:  w_next = w_rise ? OUT : BLK_WT;
      OUT:     w_next = dout_ready ? READY : OUT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_key_ok <= 1'b0;
      r_pend <= 1'b0;
      r_done_q <= 1'b0;
      r_iv <= '0;
      r_din <= '0;
      r_n3 <= '0;
      r_n4 <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      core_kload <= 1'b0;
      core_key <= '0;
      core_load <= 1'b0;
      core_pdata <= '0;
    end else begin
      r_done_q <= core_done;
      core_kload <= r_state == KEY;
      core_load <= r_state == SYNC_LD || r_state == BLK_LD;
      if (w_kwr) begin
        core_key <= key_in;
        r_pend <= w_ivwr;
      end
      if (w_ivwr) r_iv <= iv_in;
      if (r_state == KEY) r_key_ok <= 1'b1;
      if (r_state == SYNC_LD) core_pdata <= r_iv;
      if (r_state == BLK_LD) core_pdata <= w_blk;
      if (r_state == SYNC_WT && w_rise) begin
        r_n3 <= core_cdata[31:0];
        r_n4 <= core_cdata[63:32];
      end
      // N4 wraps mod 2^32-1 with end-around carry; all-ones stays all-ones
      if (r_state == STEP) begin
        r_n3 <= r_n3 + C2;
        r_n4 <= w_s4[32] ? w_s4[31:0] + 32'd1 : w_s4[31:0];
      end
      if (w_take) r_din <= din;
      if (r_state == BLK_WT && w_rise) begin
        dout <= r_din ^ core_cdata;
        dout_valid <= 1'b1;
      end
      if (r_state == OUT && dout_ready) dout_valid <= 1'b0;
    end
endmodule

// File: tb/tb_gost_gamma_ctrl.sv
// tb_gost_gamma_ctrl: scoreboard bench for gost_gamma_ctrl with a behavioural core stub
module tb_gost_gamma_ctrl;
  logic clk = 0, rst = 1;
  logic [255:0] key_in = '0;
  logic key_wr = 0, iv_wr = 0, cfb = 0, din_valid = 0, dout_ready = 1;
  logic [63:0] iv_in = '0, din = '0;
  logic din_ready, dout_valid, busy, core_kload, core_load, core_mode;
  logic [63:0] dout, core_pdata;
  logic [255:0] core_key;
  logic core_done = 0;
  logic [63:0] core_cdata = '0;
  int total = 0, bad = 0, n_kload = 0, n_load = 0;
  logic [63:0] q_out[$], q_pd[$];
  logic [255:0] q_key[$];
  logic [1:0] st_cnt = 0;
  logic st_force = 0;
  logic [63:0] st_val = 64'hFEFEFEFE_FEFEFEFB;
  localparam logic [255:0] K1 = 256'hBE5EC200_6CFF9DCF_52354959_F1FF0CBF_E95061B5_A648C103_87069C25_997C0672;
  localparam logic [255:0] K2 = 256'h01234567_89ABCDEF_FEDCBA98_76543210_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  always #5 clk = ~clk;
  gost_gamma_ctrl dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_wr(key_wr), .iv_in(iv_in), .iv_wr(iv_wr), .cfb(cfb),
    .din(din), .din_valid(din_valid), .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy), .core_kload(core_kload), .core_key(core_key),
    .core_load(core_load), .core_mode(core_mode), .core_pdata(core_pdata), .core_done(core_done),
    .core_cdata(core_cdata)
  );
  // core stub: cdata = ~pdata (or a forced synchro result for pdata 0), done rises 3 cycles after load
  always @(posedge clk)
    if (core_load) begin
      core_done <= 1'b0;
      st_cnt <= 2'd3;
      core_cdata <= (st_force && core_pdata == 64'd0) ? st_val : ~core_pdata;
    end else if (st_cnt != 0) begin
      st_cnt <= st_cnt - 2'd1;
      if (st_cnt == 2'd1) core_done <= 1'b1;
    end
  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (dout_valid && dout_ready) begin
      if (q_out.size() == 0) begin
        total++; bad++;
        $display("FAIL dout unexpected got=%0h", dout);
      end else chk("dout", dout, q_out.pop_front());
    end
    if (core_load) begin
      n_load++;
      chk("core_mode", core_mode, 0);
      if (q_pd.size() == 0) begin
        total++; bad++;
        $display("FAIL core_load unexpected pdata=%0h", core_pdata);
      end else chk("core_pdata", core_pdata, q_pd.pop_front());
    end
    if (core_kload) begin
      n_kload++;
      if (q_key.size() == 0) begin
        total++; bad++;
        $display("FAIL core_kload unexpected key=%0h", core_key);
      end else chk("core_key", core_key, q_key.pop_front());
    end
  end
  function automatic logic [63:0] nxt(input logic [63:0] n);
    logic [63:0] a;
    logic [31:0] n3;
    n3 = n[31:0] + 32'h01010104;
    a = {32'd0, n[63:32]} + 64'h01010101;
    if (a > 64'hFFFFFFFF) a = a - 64'hFFFFFFFF;
    return {a[31:0], n3};
  endfunction
  task automatic wait_free(input string nm);
    int n = 0;
    while ((busy || dout_valid) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (busy || dout_valid) begin
      total++; bad++;
      $display("FAIL %s timeout busy=%0b dout_valid=%0b exp=0", nm, busy, dout_valid);
    end
  endtask
  task automatic wr_key(input logic [255:0] k);
    key_in = k; key_wr = 1;
    @(posedge clk); #1;
    key_wr = 0;
  endtask
  task automatic wr_iv(input logic [63:0] v);
    iv_in = v; iv_wr = 1;
    @(posedge clk); #1;
    iv_wr = 0;
  endtask
  task automatic send(input logic [63:0] d, input logic [63:0] e, input bit push);
    int n = 0;
    while (!din_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (!din_ready) begin
      total++; bad++;
      $display("FAIL din_ready timeout got=0 exp=1");
    end
    din = d; din_valid = 1;
    if (push) q_out.push_back(e);
    @(posedge clk); #1;
    din_valid = 0;
  endtask
  initial begin
    logic [63:0] n, rv;
    logic [63:0] d [4];
    logic [63:0] c [4];
    int kb, lb, w;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_din_ready", din_ready, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_core_load", core_load, 0);
    chk("rst_core_kload", core_kload, 0);
    chk("rst_core_pdata", core_pdata, 0);
    chk("rst_core_key", core_key, 0);
    rst = 0;
    @(posedge clk); #1;
    // basic block: synchro all-ones makes the stub return S=0
    q_key.push_back(K1);
    wr_key(K1);
    wait_free("key1");
    q_pd.push_back(64'hFFFFFFFF_FFFFFFFF);
    wr_iv(64'hFFFFFFFF_FFFFFFFF);
    q_pd.push_back(64'h01010101_01010104);
    send(64'd0, 64'hFEFEFEFE_FEFEFEFB, 1);
    q_pd.push_back(64'h02020202_02020208);
    send(64'hAAAAAAAA_55555555, 64'h57575757_A8A8A8A2, 1);
    wait_free("basic");
    // counter wrap: S forced to FEFEFEFE_FEFEFEFB
    st_force = 1;
    q_pd.push_back(64'd0);
    wr_iv(64'd0);
    q_pd.push_back(64'hFFFFFFFF_FFFFFFFF);
    send(64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 1);
    q_pd.push_back(64'h01010101_01010103);
    send(64'd0, 64'hFEFEFEFE_FEFEFEFC, 1);
    wait_free("wrap");
    st_force = 0;
    // backpressure
    dout_ready = 0;
    q_pd.push_back(64'h02020202_02020207);
    send(64'd0, 64'hFDFDFDFD_FDFDFDF8, 1);
    w = 0;
    while (!dout_valid && w < 100) begin
      @(posedge clk); #1; w++;
    end
    chk("bp_valid", dout_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_dout", dout, 64'hFDFDFDFD_FDFDFDF8);
      chk("bp_din_ready", din_ready, 0);
    end
    @(posedge clk); #1;
    dout_ready = 1;
    wait_free("bp");
    // key_wr and iv_wr together in READY
    kb = n_kload; lb = n_load;
    q_key.push_back(K2);
    q_pd.push_back(64'h00000000_FFFFFFFF);
    key_in = K2; iv_in = 64'h00000000_FFFFFFFF; key_wr = 1; iv_wr = 1;
    @(posedge clk); #1;
    key_wr = 0; iv_wr = 0;
    w = 0;
    while (!din_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    chk("both_kloads", n_kload - kb, 1);
    chk("both_loads", n_load - lb, 1);
    q_pd.push_back(64'h01010101_01010104);
    send(64'd0, 64'hFEFEFEFE_FEFEFEFB, 1);
    wait_free("both");
    // round trip: encrypt 4 blocks, reload IV, feed results back
    d = '{64'h00112233_44556677, 64'h8899AABB_CCDDEEFF, 64'hDEADBEEF_CAFEF00D, 64'h0};
    rv = 64'h01234567_89ABCDEF;
    q_pd.push_back(rv);
    wr_iv(rv);
    n = ~rv;
    for (int i = 0; i < 4; i++) begin
      n = nxt(n);
      c[i] = d[i] ^ ~n;
      q_pd.push_back(n);
      send(d[i], c[i], 1);
    end
    wait_free("enc");
    q_pd.push_back(rv);
    wr_iv(rv);
    n = ~rv;
    for (int i = 0; i < 4; i++) begin
      n = nxt(n);
      q_pd.push_back(n);
      send(c[i], d[i], 1);
    end
    wait_free("dec");
    // reset during BLK_WT
    q_pd.push_back(64'hFFFFFFFF_FFFFFFFF);
    wr_iv(64'hFFFFFFFF_FFFFFFFF);
    q_pd.push_back(64'h01010101_01010104);
    send(64'd0, 64'd0, 0);
    w = 0;
    do begin
      @(negedge clk); w++;
    end while (!core_load && w < 50);
    chk("abort_load_seen", core_load, 1);
    #2 rst = 1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_dout_valid", dout_valid, 0);
    chk("abort_dout", dout, 0);
    chk("abort_core_load", core_load, 0);
    chk("abort_core_pdata", core_pdata, 0);
    chk("abort_core_key", core_key, 0);
    chk("abort_din_ready", din_ready, 0);
    @(posedge clk); #1;
    rst = 0;
    lb = n_load;
    wr_iv(64'h55555555_AAAAAAAA);
    repeat (12) @(posedge clk);
    #1;
    chk("nokey_loads", n_load - lb, 0);
    chk("nokey_busy", busy, 0);
    // recovery after reset
    q_key.push_back(K1);
    wr_key(K1);
    wait_free("key2");
    q_pd.push_back(64'hFFFFFFFF_FFFFFFFF);
    wr_iv(64'hFFFFFFFF_FFFFFFFF);
    q_pd.push_back(64'h01010101_01010104);
    send(64'hFFFFFFFF_00000000, 64'h01010101_FEFEFEFB, 1);
    wait_free("recover");
    repeat (2) @(posedge clk);
    chk("q_out_left", q_out.size(), 0);
    chk("q_pd_left", q_pd.size(), 0);
    chk("q_key_left", q_key.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
